iob_clint_rearm: RTL

Hardware periodic-timer engine that acts as a bus initiator toward the CLINT and drives its native iob interface (valid/address/wdata/wstrb → rdata/ready). On enable it reads `mtime` and programs one hart's `mtimecmp` to `mtime + period`. Each time that hart's `mtip` fires, it re-arms `mtimecmp` to the previous compare value plus `period`, giving drift-free periodic interrupts without software involvement. It sits beside the CPU and shares the CLINT through the system bus interconnect.

---
 rtl/iob_clint_rearm_pkg.sv | 33 +++
 rtl/iob_clint_rearm_txn.sv | 58 +++++
 rtl/iob_clint_rearm.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/iob_clint_rearm_pkg.sv
// Shared constants, FSM encoding and helpers for the CLINT periodic re-arm engine.
package iob_clint_rearm_pkg;

    localparam logic [31:0] MTIME_LO      = 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI      = 32'h0000_BFFC;
    localparam logic [31:0] MTIMECMP_BASE = 32'h0000_4000;
    localparam logic [31:0] ALL_ONES      = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RD_HI0   = 4'd1,
        ST_RD_LO    = 4'd2,
        ST_RD_HI1   = 4'd3,
        ST_WR_LOMAX = 4'd4,
        ST_WR_HI    = 4'd5,
        ST_WR_LO    = 4'd6,
        ST_ARMED    = 4'd7,
        ST_DIS_HI   = 4'd8,
        ST_DIS_LO   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_REQ  = 2'd1,
        PH_GAP  = 2'd2
    } phase_t;

    // Every state other than IDLE and ARMED owns exactly one bus transaction.
    function automatic logic is_bus_state(input state_t s);
        return (s != ST_IDLE) && (s != ST_ARMED);
    endfunction

endpackage

// File: rtl/iob_clint_rearm_txn.sv
// Single iob transaction engine: REQ holds valid until ready, then one GAP cycle.
module iob_clint_rearm_txn
    import iob_clint_rearm_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                we,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    phase_t phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= PH_IDLE;
            m_address <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
        end else begin
            // NOTE: non-blocking (<=) for all state so every flop sees pre-edge values.
            case (phase)
                PH_REQ: begin
                    if (m_ready) phase <= PH_GAP;
                end
                default: begin
                    // A new request may launch from GAP, so valid is low for exactly one cycle.
                    if (start) begin
                        phase     <= PH_REQ;
                        m_address <= addr;
                        m_wdata   <= wdata;
                        m_wstrb   <= {(DATA_W/8){we}};
                    end else begin
                        phase <= PH_IDLE;
                    end
                end
            endcase
        end
    end

    // Ready is only honoured while a request is outstanding; the lingering ready in GAP is ignored.
    assign m_valid = (phase == PH_REQ);
    assign done    = m_valid && m_ready;
    assign rdata   = m_rdata;

endmodule

// File: rtl/iob_clint_rearm.sv
// Periodic mtimecmp re-arm engine: reads mtime, programs mtimecmp, re-arms on every mtip.
module iob_clint_rearm
    import iob_clint_rearm_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int HART_ID  = 0,
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                mtip_in,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,
    output logic                tick,
    output logic                busy,
    output logic [31:0]         rearm_cnt
);

    localparam logic [ADDR_W-1:0] CMP_LO   = ADDR_W'(MTIMECMP_BASE + 32'(8 * HART_ID));
    localparam logic [ADDR_W-1:0] CMP_HI   = ADDR_W'(MTIMECMP_BASE + 32'(8 * HART_ID + 4));
    localparam logic [ADDR_W-1:0] MT_LO    = ADDR_W'(MTIME_LO);
    localparam logic [ADDR_W-1:0] MT_HI    = ADDR_W'(MTIME_HI);

    state_t              state;
    logic [63:0]         cmp;
    logic [31:0]         hi0;
    logic [31:0]         lo;
    logic                rearm;
    logic [63:0]         period_x;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                req_we;
    logic                txn_done;
    logic [DATA_W-1:0]   txn_rdata;

    assign period_x = 64'(period);
    assign busy     = is_bus_state(state);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path infers a latch.
        req_addr  = CMP_LO;
        req_wdata = ALL_ONES;
        req_we    = 1'b1;
        case (state)
            ST_RD_HI0, ST_RD_HI1: begin
                req_addr  = MT_HI;
                req_wdata = '0;
                req_we    = 1'b0;
            end
            ST_RD_LO: begin
                req_addr  = MT_LO;
                req_wdata = '0;
                req_we    = 1'b0;
            end
            ST_WR_HI: begin
                req_addr  = CMP_HI;
                req_wdata = cmp[63:32];
            end
            ST_WR_LO:  req_wdata = cmp[31:0];
            ST_DIS_HI: req_addr  = CMP_HI;
            default: ;
        endcase
    end

    iob_clint_rearm_txn #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_txn (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (busy),
        .addr      (req_addr),
        .wdata     (req_wdata),
        .we        (req_we),
        .done      (txn_done),
        .rdata     (txn_rdata),
        .m_valid   (m_valid),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmp       <= '0;
            hi0       <= '0;
            lo        <= '0;
            rearm     <= 1'b0;
            tick      <= 1'b0;
            rearm_cnt <= '0;
        end else begin
            tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_RD_HI0;
                end
                ST_ARMED: begin
                    if (!enable || (mtip_in && period_x == 64'd0)) begin
                        state <= ST_DIS_HI;
                    end else if (mtip_in) begin
                        cmp   <= cmp + period_x;
                        rearm <= 1'b1;
                        state <= ST_WR_LOMAX;
                    end
                end
                default: begin
                    // Bus states advance only on handshake, so a transaction is never abandoned.
                    if (txn_done) begin
                        if (!enable && state != ST_DIS_HI && state != ST_DIS_LO) begin
                            state <= ST_DIS_HI;
                        end else begin
                            case (state)
                                ST_RD_HI0: begin
                                    hi0   <= txn_rdata;
                                    state <= ST_RD_LO;
                                end
                                ST_RD_LO: begin
                                    lo    <= txn_rdata;
                                    state <= ST_RD_HI1;
                                end
                                ST_RD_HI1: begin
                                    if (txn_rdata != hi0) begin
                                        state <= ST_RD_HI0;
                                    end else if (period_x == 64'd0) begin
                                        state <= ST_DIS_HI;
                                    end else begin
                                        cmp   <= {txn_rdata, lo} + period_x;
                                        rearm <= 1'b0;
                                        state <= ST_WR_LOMAX;
                                    end
                                end
                                ST_WR_LOMAX: state <= ST_WR_HI;
                                ST_WR_HI:    state <= ST_WR_LO;
                                ST_WR_LO: begin
                                    state <= ST_ARMED;
                                    if (rearm) begin
                                        tick      <= 1'b1;
                                        rearm_cnt <= rearm_cnt + 32'd1;
                                    end
                                end
                                ST_DIS_HI:   state <= ST_DIS_LO;
                                default:     state <= ST_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
